pwm_multi: RTL and testbench

Multi-channel, parametrised PWM generator with built-in prescaler and double-buffered duty registers. It replaces the fixed four-output, fixed-period PWM and its separate clock divider. All channels share one period counter; each channel compares against its own duty value. It sits between the system clock domain (`clk_in`) and pin-level PWM outputs, programmed by a simple write strobe interface.

---
 rtl/pwm_multi.sv | 137 +++++++++++++
 tb/tb_pwm_multi.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared prescaled period counter and double-buffered duty/period.
// Define PWM_CENTER_EN for center-aligned (up/down) counting; default is edge-aligned.

module pwm_multi_lane #(
  parameter int W = 9
)(
  input  logic         clk_in,
  input  logic         rst,
  input  logic         en,
  input  logic         wr,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic [W-1:0] cmp_cnt,
  output logic         pwm
);
  logic [W-1:0] duty_sh, duty_act, duty_act_next;

  // Compare against the value that becomes active on this edge so a boundary load has no glitch
  assign duty_act_next = load ? duty_sh : duty_act;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (wr) duty_sh <= data;
      duty_act <= duty_act_next;
      pwm      <= en && (cmp_cnt < duty_act_next);
    end
  end
endmodule

module pwm_multi #(
  parameter int CH  = 4,
  parameter int W   = 9,
  parameter int DIV = 1000,
  parameter int SW  = (CH > 1) ? $clog2(CH) : 1
)(
  input  logic          clk_in,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  period,
  input  logic          duty_wr,
  input  logic [SW-1:0] duty_sel,
  input  logic [W-1:0]  duty_data,
  output logic [CH-1:0] pwm_out,
  output logic          period_start
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre;
  logic [W-1:0]  cnt, cnt_next, cmp_cnt, period_act, p_eff;
  logic          tick, boundary, load;

`ifdef PWM_CENTER_EN
  logic dn, dn_next;

  // Up phase covers 0..P-1, down phase P..1; comparing cnt-1 while down gives
  // exactly duty ticks on each side of the valley.
  always_comb begin
    p_eff    = (period_act == '0) ? W'(1) : period_act;
    tick     = en && (pre == PW'(DIV - 1));
    cnt_next = cnt;
    dn_next  = dn;
    boundary = 1'b0;
    if (!en) begin
      cnt_next = '0;
      dn_next  = 1'b0;
    end else if (tick) begin
      if (!dn) begin
        cnt_next = cnt + W'(1);
        if (cnt_next >= p_eff) dn_next = 1'b1;
      end else if (cnt <= W'(1)) begin
        cnt_next = '0;
        dn_next  = 1'b0;
        boundary = 1'b1;
      end else begin
        cnt_next = cnt - W'(1);
      end
    end
    cmp_cnt = cnt_next - W'(dn_next);
    load    = !en || boundary;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) dn <= 1'b0;
    else     dn <= dn_next;
  end
`else
  always_comb begin
    p_eff    = (period_act == '0) ? W'(1) : period_act;
    tick     = en && (pre == PW'(DIV - 1));
    cnt_next = cnt;
    boundary = 1'b0;
    if (!en) begin
      cnt_next = '0;
    end else if (tick) begin
      if (cnt >= p_eff - W'(1)) begin
        cnt_next = '0;
        boundary = 1'b1;
      end else begin
        cnt_next = cnt + W'(1);
      end
    end
    cmp_cnt = cnt_next;
    load    = !en || boundary;
  end
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pre          <= '0;
      cnt          <= '0;
      period_act   <= '1;
      period_start <= 1'b0;
    end else begin
      pre          <= (!en || tick) ? '0 : pre + PW'(1);
      cnt          <= cnt_next;
      period_start <= boundary;
      if (load) period_act <= period;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    pwm_multi_lane #(.W(W)) u_lane (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en),
      .wr      (duty_wr && (duty_sel == SW'(i))),
      .load    (load),
      .data    (duty_data),
      .cmp_cnt (cmp_cnt),
      .pwm     (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi (edge-aligned build): vector table, directed period sequences,
// and randomized traffic against a cycles-elapsed-in-period reference model.

module tb_pwm_multi;
  localparam int CH = 4, W = 8, DIV = 4, SW = 2;

  logic          clk_in = 1'b0, rst = 1'b1, en = 1'b0, duty_wr = 1'b0;
  logic [W-1:0]  period = 8'd10, duty_data = '0;
  logic [SW-1:0] duty_sel = '0;
  logic [CH-1:0] pwm_out;
  logic          period_start;

  int n_vec = 0, n_err = 0;

  pwm_multi #(.CH(CH), .W(W), .DIV(DIV)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .period(period),
    .duty_wr(duty_wr), .duty_sel(duty_sel), .duty_data(duty_data),
    .pwm_out(pwm_out), .period_start(period_start)
  );

  always #5 clk_in = ~clk_in;

  // Reference: m_c = clk cycles elapsed in the current period; ticks = m_c / DIV.
  int            m_sh[CH], m_act[CH];
  int            m_p, m_c;
  logic [CH-1:0] m_pwm;
  logic          m_ps;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin m_sh[i] = 0; m_act[i] = 0; end
    m_p = 255; m_c = 0; m_pwm = '0; m_ps = 1'b0;
  endtask

  task automatic model_edge();
    int peff;
    if (rst) begin model_reset(); return; end
    m_ps = 1'b0;
    if (!en) begin
      for (int i = 0; i < CH; i++) m_act[i] = m_sh[i];
      m_p = int'(period); m_c = 0; m_pwm = '0;
    end else begin
      peff = (m_p == 0) ? 1 : m_p;
      m_c++;
      if (m_c == peff * DIV) begin
        m_c = 0; m_ps = 1'b1; m_p = int'(period);
        for (int i = 0; i < CH; i++) m_act[i] = m_sh[i];
      end
      for (int i = 0; i < CH; i++) m_pwm[i] = ((m_c / DIV) < m_act[i]);
    end
    if (duty_wr && int'(duty_sel) < CH) m_sh[duty_sel] = int'(duty_data);
  endtask

  task automatic cyc();
    @(posedge clk_in);
    model_edge();
    #1;
    check("model_pwm", 32'(pwm_out), 32'(m_pwm));
    check("model_ps", 32'(period_start), 32'(m_ps));
  endtask

  task automatic wr(input int sel, input int data);
    duty_wr = 1'b1; duty_sel = SW'(sel); duty_data = W'(data);
    cyc();
    duty_wr = 1'b0;
  endtask

  // Runs from the current sample to the next period_start sample.
  task automatic period_meas(output int len, output int hi0, output int hi1, output int lo2);
    len = 0; hi0 = int'(pwm_out[0]); hi1 = int'(pwm_out[1]); lo2 = int'(!pwm_out[2]);
    do begin
      cyc(); len++;
      if (!period_start) begin
        hi0 += int'(pwm_out[0]); hi1 += int'(pwm_out[1]); lo2 += int'(!pwm_out[2]);
      end
    end while (!period_start && len < 1500);
    if (!period_start) check("ps_timeout", 32'(len), 32'(0));
  endtask

  typedef struct {
    logic rst, en, wr;
    logic [SW-1:0] sel;
    logic [W-1:0] data;
    logic [CH-1:0] pwm;
    logic ps;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int len, hi0, hi1, lo2, t1, t2, cnt;
    model_reset();
    tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0,   4'b0000, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 2'd0, 8'd3,   4'b0000, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 2'd1, 8'd0,   4'b0000, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 2'd2, 8'd255, 4'b0000, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 2'd3, 8'd10,  4'b0000, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0,   4'b0000, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0,   4'b1101, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0,   4'b1101, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'd0,   4'b1101, 1'b0};
    #2;
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; duty_wr = tbl[i].wr;
      duty_sel = tbl[i].sel; duty_data = tbl[i].data;
      cyc();
      check($sformatf("tbl%0d_pwm", i), 32'(pwm_out), 32'(tbl[i].pwm));
      check($sformatf("tbl%0d_ps", i), 32'(period_start), 32'(tbl[i].ps));
    end
    duty_wr = 1'b0;

    // Basic duty and limits: first boundary 39 cycles after the enable edge
    period_meas(len, hi0, hi1, lo2);
    check("first_ps_delay", 32'(len), 32'(37));
    t1 = 0; t2 = 0;
    for (int p = 0; p < 3; p++) begin
      period_meas(len, hi0, hi1, lo2);
      check("basic_len", 32'(len), 32'(40));
      check("basic_hi0", 32'(hi0), 32'(12));
      t1 += hi1; t2 += lo2;
    end
    check("lim_duty0_low", 32'(t1), 32'(0));
    check("lim_dutyfull_high", 32'(t2), 32'(0));

    // Shadow update mid-period at cnt=5
    for (int k = 0; k < 5 * DIV; k++) cyc();
    wr(0, 7);
    period_meas(len, hi0, hi1, lo2);
    check("shadow_cur_len", 32'(len), 32'(19));
    check("shadow_cur_hi0", 32'(hi0), 32'(0));
    period_meas(len, hi0, hi1, lo2);
    check("shadow_next_hi0", 32'(hi0), 32'(28));

    // Write coinciding with the boundary load
    for (int k = 0; k < 39; k++) cyc();
    wr(0, 2);
    check("bwr_ps", 32'(period_start), 32'(1));
    period_meas(len, hi0, hi1, lo2);
    check("bwr_old_hi0", 32'(hi0), 32'(28));
    period_meas(len, hi0, hi1, lo2);
    check("bwr_new_hi0", 32'(hi0), 32'(8));

    // Period change 10 -> 6 mid-period
    for (int k = 0; k < 12; k++) cyc();
    period = 8'd6;
    period_meas(len, hi0, hi1, lo2);
    check("per_cur_len", 32'(len), 32'(28));
    period_meas(len, hi0, hi1, lo2);
    check("per_new_len", 32'(len), 32'(24));
    check("per_new_hi0", 32'(hi0), 32'(8));
    check("per_new_lo2", 32'(lo2), 32'(0));

    // Asynchronous reset at cnt=4
    for (int k = 0; k < 4 * DIV; k++) cyc();
    #2 rst = 1'b1;
    #1;
    check("rst_async_pwm", 32'(pwm_out), 32'(0));
    check("rst_async_ps", 32'(period_start), 32'(0));
    model_reset();
    cyc(); cyc();
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 72; k++) begin cyc(); cnt += int'(pwm_out != '0); end
    check("rst_after_low", 32'(cnt), 32'(0));

    // en low -> high restarts from cnt=0
    wr(0, 3); wr(1, 1);
    en = 1'b0; cyc(); cyc();
    en = 1'b1; cyc();
    check("en_restart_pwm01", 32'(pwm_out[1:0]), 32'(2'b11));
    period_meas(len, hi0, hi1, lo2);
    check("en_restart_first_ps", 32'(len), 32'(23));
    period_meas(len, hi0, hi1, lo2);
    check("en_restart_len", 32'(len), 32'(24));
    check("en_restart_hi0", 32'(hi0), 32'(12));

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(99) < 12) begin
        duty_wr = 1'b1; duty_sel = SW'($urandom_range(CH - 1));
        duty_data = ($urandom_range(9) == 0) ? 8'd255 : W'($urandom_range(14));
      end
      if ($urandom_range(99) < 2) period = W'($urandom_range(12));
      if ($urandom_range(199) < 2) en = ~en;
      rst = ($urandom_range(999) < 3);
      cyc();
      duty_wr = 1'b0; rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
